// File: rtl/weight_streamer.sv
// weight_streamer
//   Streams weight rows from two read-only weight memories into a
//   consuming tile. Channel 0 walks IMG_SZ rows of layer-0 weights,
//   channel 1 walks NUM_NEURONS rows of layer-1 weights. Each channel is
//   an independent IDLE -> ISSUE -> DRAIN FSM; both may run at once.
//
// Handshake: get_weightsN is a one-cycle request pulse. A request seen
//   while the channel is idle starts a stream; row k is presented on
//   weightsN exactly k+1 cycles after the request, rows back to back.
//   A request on a non-idle channel is dropped and flagged by a one-cycle
//   overrun pulse in the following cycle. The memories have a fixed
//   one-cycle read latency, so no backpressure exists on either side.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   get_weights0/1       stream request pulses
//   weights0/1           presented weight row (all-zero when no row valid)
//   w0_rd_en/addr/data   layer-0 memory read port (data 1 cycle after en)
//   w1_rd_en/addr/data   layer-1 memory read port (data 1 cycle after en)
//   busy0/1              channel streaming (cycle after request .. last row)
//   last0/1              high with the final row of a stream
//   overrun              one-cycle pulse after a request on a busy channel
//   dbg_state0/1         FSM state of each channel (0 idle, 1 issue, 2 drain)

module weight_streamer_ch #(
    parameter int ROWS  = 4,
    parameter int LANES = 3,
    parameter int AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   get,
    output logic                   rd_en,
    output logic [AW-1:0]          rd_addr,
    input  logic [LANES-1:0][31:0] rd_data,
    output logic [LANES-1:0][31:0] weights,
    output logic                   busy,
    output logic                   last,
    output logic                   req_while_busy,
    output logic [1:0]             state_dbg
);
    localparam int CW = $clog2(ROWS) + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            S_IDLE: begin
                // Address 0 goes out in the request cycle itself; gated by
                // rst so a request held during reset issues nothing.
                if (get && !rst) begin
                    rd_en = 1'b1;
                    if (ROWS == 1) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_ISSUE: begin
                rd_en   = 1'b1;
                rd_addr = cnt_q[AW-1:0];
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // Last row is on the bus this cycle; nothing left to issue.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        valid_d = rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Zero outside valid rows so extra accumulate cycles in the tile add 0.
    assign weights        = valid_q ? rd_data : '0;
    // The only valid row presented while in DRAIN is the final one.
    assign last           = valid_q && (state_q == S_DRAIN);
    assign busy           = (state_q != S_IDLE);
    assign req_while_busy = get && (state_q != S_IDLE);
    assign state_dbg      = state_q;
endmodule

module weight_streamer #(
    parameter int NUM_NEURONS = 128,
    parameter int IMG_SZ      = 784,
    parameter int OUTPUT_SZ   = 10,
    localparam int AW0 = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1,
    localparam int AW1 = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         get_weights0,
    input  logic                         get_weights1,
    output logic [NUM_NEURONS-1:0][31:0] weights0,
    output logic [OUTPUT_SZ-1:0][31:0]   weights1,
    output logic                         w0_rd_en,
    output logic [AW0-1:0]               w0_rd_addr,
    input  logic [NUM_NEURONS-1:0][31:0] w0_rd_data,
    output logic                         w1_rd_en,
    output logic [AW1-1:0]               w1_rd_addr,
    input  logic [OUTPUT_SZ-1:0][31:0]   w1_rd_data,
    output logic                         busy0,
    output logic                         busy1,
    output logic                         last0,
    output logic                         last1,
    output logic                         overrun,
    output logic [1:0]                   dbg_state0,
    output logic [1:0]                   dbg_state1
);
    logic rwb0, rwb1;
    logic overrun_q, overrun_d;

    weight_streamer_ch #(.ROWS(IMG_SZ), .LANES(NUM_NEURONS), .AW(AW0)) u_ch0 (
        .clk            (clk),
        .rst            (rst),
        .get            (get_weights0),
        .rd_en          (w0_rd_en),
        .rd_addr        (w0_rd_addr),
        .rd_data        (w0_rd_data),
        .weights        (weights0),
        .busy           (busy0),
        .last           (last0),
        .req_while_busy (rwb0),
        .state_dbg      (dbg_state0)
    );

    weight_streamer_ch #(.ROWS(NUM_NEURONS), .LANES(OUTPUT_SZ), .AW(AW1)) u_ch1 (
        .clk            (clk),
        .rst            (rst),
        .get            (get_weights1),
        .rd_en          (w1_rd_en),
        .rd_addr        (w1_rd_addr),
        .rd_data        (w1_rd_data),
        .weights        (weights1),
        .busy           (busy1),
        .last           (last1),
        .req_while_busy (rwb1),
        .state_dbg      (dbg_state1)
    );

    always_comb begin
        overrun_d = rwb0 || rwb1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
endmodule

// File: tb/tb_weight_streamer.sv
module tb_weight_streamer;
    localparam int NN  = 3;
    localparam int IMG = 4;
    localparam int OSZ = 2;
    localparam int W0  = NN * 32 + 2;
    localparam int W1  = OSZ * 32 + 2;
    localparam int WT  = W0 + W1 + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 get_weights0 = 1'b0;
    logic                 get_weights1 = 1'b0;
    logic [NN-1:0][31:0]  weights0;
    logic [OSZ-1:0][31:0] weights1;
    logic                 w0_rd_en;
    logic [1:0]           w0_rd_addr;
    logic [NN-1:0][31:0]  w0_rd_data;
    logic                 w1_rd_en;
    logic [1:0]           w1_rd_addr;
    logic [OSZ-1:0][31:0] w1_rd_data;
    logic                 busy0, busy1, last0, last1, overrun;
    logic [1:0]           dbg_state0, dbg_state1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: one entry per cycle of a stream, {busy, last, row}.
    logic [W0-1:0] exp0_q[$];
    logic [W1-1:0] exp1_q[$];
    logic          exp_ovr = 1'b0;
    int            left0 = 0;
    int            left1 = 0;

    weight_streamer #(.NUM_NEURONS(NN), .IMG_SZ(IMG), .OUTPUT_SZ(OSZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .get_weights0 (get_weights0),
        .get_weights1 (get_weights1),
        .weights0     (weights0),
        .weights1     (weights1),
        .w0_rd_en     (w0_rd_en),
        .w0_rd_addr   (w0_rd_addr),
        .w0_rd_data   (w0_rd_data),
        .w1_rd_en     (w1_rd_en),
        .w1_rd_addr   (w1_rd_addr),
        .w1_rd_data   (w1_rd_data),
        .busy0        (busy0),
        .busy1        (busy1),
        .last0        (last0),
        .last1        (last1),
        .overrun      (overrun),
        .dbg_state0   (dbg_state0),
        .dbg_state1   (dbg_state1)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Memory models: row = addr+1 in every lane, garbage when not read.
    always @(posedge clk) begin
        for (int i = 0; i < NN; i++)
            w0_rd_data[i] <= w0_rd_en ? 32'(w0_rd_addr) + 32'd1 : $urandom;
        for (int i = 0; i < OSZ; i++)
            w1_rd_data[i] <= w1_rd_en ? 32'(w1_rd_addr) + 32'd1 : $urandom;
    end

    function automatic logic [NN*32-1:0] row0(input int v);
        logic [NN*32-1:0] r;
        for (int i = 0; i < NN; i++) r[i*32 +: 32] = 32'(v);
        return r;
    endfunction

    function automatic logic [OSZ*32-1:0] row1(input int v);
        logic [OSZ*32-1:0] r;
        for (int i = 0; i < OSZ; i++) r[i*32 +: 32] = 32'(v);
        return r;
    endfunction

    function automatic logic [WT-1:0] observed();
        return {overrun, busy1, last1, weights1, busy0, last0, weights0};
    endfunction

    // Driver: new inputs 1 time unit after the active edge.
    task automatic step(input logic g0, input logic g1);
        @(posedge clk);
        #1;
        get_weights0 = g0;
        get_weights1 = g1;
    endtask

    // Expected outputs for the current cycle.
    task automatic sb_pop(output logic [WT-1:0] e);
        logic [W0-1:0] e0;
        logic [W1-1:0] e1;
        e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : '0;
        e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : '0;
        e  = {exp_ovr, e1, e0};
    endtask

    // Model of the request acceptance; pushes the stream the request produces.
    task automatic model_req(input logic g0, input logic g1);
        logic idle0, idle1;
        idle0   = (left0 == 0);
        idle1   = (left1 == 0);
        exp_ovr = (g0 && !idle0) || (g1 && !idle1);
        if (g0 && idle0) begin
            for (int k = 0; k < IMG; k++)
                exp0_q.push_back({1'b1, (k == IMG - 1), row0(k + 1)});
            left0 = IMG;
        end else if (left0 > 0) begin
            left0--;
        end
        if (g1 && idle1) begin
            for (int k = 0; k < NN; k++)
                exp1_q.push_back({1'b1, (k == NN - 1), row1(k + 1)});
            left1 = NN;
        end else if (left1 > 0) begin
            left1--;
        end
    endtask

    task automatic model_reset();
        exp0_q.delete();
        exp1_q.delete();
        exp_ovr = 1'b0;
        left0   = 0;
        left1   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        get_weights0 = 1'b1;
        get_weights1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h exp 0", observed());
        end
        n_checks++;
        if ({w0_rd_en, w1_rd_en, dbg_state0, dbg_state1} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_rd_en_state got %b exp 0",
                     {w0_rd_en, w1_rd_en, dbg_state0, dbg_state1});
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        get_weights0 = 1'b0;
        get_weights1 = 1'b0;
        model_reset();
    endtask

    task automatic test_stream0();
        logic [WT-1:0] e;
        for (int c = 0; c < 8; c++) begin
            step(c == 0, 1'b0);
            @(negedge clk);
            n_checks++;
            if ({w0_rd_en, w0_rd_addr} !== {(c < IMG), (c < IMG) ? 2'(c) : 2'd0}) begin
                n_fail++;
                $display("FAIL stream0_addr c%0d got en=%b addr=%0d", c, w0_rd_en, w0_rd_addr);
            end
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL stream0 c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    task automatic test_stream1();
        logic [WT-1:0] e;
        for (int c = 0; c < 7; c++) begin
            step(1'b0, c == 0);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL stream1 c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    task automatic test_both();
        logic [WT-1:0] e;
        for (int c = 0; c < 8; c++) begin
            step(c == 0, c == 0);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL both c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    // Repeat at cycle 2 and a request on the DRAIN cycle (cycle 4).
    task automatic test_overrun();
        logic [WT-1:0] e;
        for (int c = 0; c < 12; c++) begin
            step(c == 0 || c == 2 || c == 4, c == 1 || c == 3);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL overrun c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    task automatic test_reset_mid();
        logic [WT-1:0] e;
        for (int c = 0; c < 3; c++) begin
            step(c == 0, 1'b0);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy0, w0_rd_en, weights0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async got busy=%b en=%b w=%h", busy0, w0_rd_en, weights0);
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 7; c++) begin
            step(c == 0, 1'b0);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL reset_mid_post c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    task automatic test_back_to_back();
        logic [WT-1:0] e;
        for (int c = 0; c < 13; c++) begin
            step(c == 0 || c == 6, c == 5 || c == 9);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    task automatic test_random();
        logic [WT-1:0] e;
        for (int c = 0; c < 80; c++) begin
            step(c < 72 && $urandom_range(0, 3) == 0, c < 72 && $urandom_range(0, 2) == 0);
            @(negedge clk);
            sb_pop(e);
            n_checks++;
            if (observed() !== e) begin
                n_fail++;
                $display("FAIL random c%0d got %h exp %h", c, observed(), e);
            end
            model_req(get_weights0, get_weights1);
        end
    endtask

    initial begin
        test_reset();
        test_stream0();
        test_stream1();
        test_both();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
